// File: rtl/lsu_mem_bridge.sv
// Bridge between fu_lsu raw memory pins and a single-port valid/ready memory bus.
// Stores drain through a small write buffer; loads forward from it or go to memory.
module lsu_mem_bridge #(
    parameter int unsigned WB_DEPTH  = 4,
    parameter int unsigned ADDR_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lsu_ren,
    input  logic [ADDR_BITS-1:0] lsu_raddr,
    output logic                 lsu_rvalid,
    output logic [63:0]          lsu_rdata,
    input  logic                 lsu_wen,
    input  logic [ADDR_BITS-1:0] lsu_waddr,
    input  logic [63:0]          lsu_wdata,
    output logic                 wb_full,
    output logic                 err_sticky,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [63:0]          mem_req_wdata,
    input  logic                 mem_resp_valid,
    input  logic [63:0]          mem_resp_rdata
);

    localparam int unsigned PW = $clog2(WB_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_t;

    rd_state_t state_q, state_d;

    logic [ADDR_BITS-1:0] wb_addr [WB_DEPTH];
    logic [63:0]          wb_data [WB_DEPTH];
    logic [PW-1:0]        head_q, tail_q, idx, cand_idx;
    logic [CW-1:0]        count_q, count_d;

    logic [ADDR_BITS-1:0] rd_addr_q, rd_issue_addr;
    logic                 rd_issued_q;

    logic                 req_valid_q, req_we_q;
    logic [ADDR_BITS-1:0] req_addr_q;
    logic [63:0]          req_wdata_q;

    logic                 rvalid_q, full_q, err_q;
    logic [63:0]          rdata_q;

    logic hs, free, wr_inflight, deq, enq, drop;
    logic fwd_hit, fwd_take, miss, resp_take, proto_err, issue_rd, issue_wr;
    logic [63:0] fwd_data;

    function automatic logic same_line(input logic [ADDR_BITS-1:0] a,
                                       input logic [ADDR_BITS-1:0] b);
        return a[ADDR_BITS-1:3] == b[ADDR_BITS-1:3];
    endfunction

    always_comb begin
        hs          = req_valid_q && mem_req_ready;
        free        = !req_valid_q || mem_req_ready;
        wr_inflight = req_valid_q && req_we_q;
        deq         = hs && req_we_q;
        enq         = lsu_wen && (count_q != CW'(WB_DEPTH));
        drop        = lsu_wen && !enq;
        count_d     = count_q + CW'(enq) - CW'(deq);
    end

    // Oldest-to-youngest scan so the last match wins; the head copy already on the bus is skipped.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && !((i == 0) && wr_inflight) &&
                same_line(wb_addr[idx], lsu_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data[idx];
            end
        end
        if (enq && same_line(lsu_waddr, lsu_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = lsu_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        fwd_take  = 1'b0;
        miss      = 1'b0;
        resp_take = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (lsu_ren) begin
                    if (fwd_hit) begin
                        fwd_take = 1'b1;
                    end else begin
                        miss    = 1'b1;
                        state_d = R_REQ;
                    end
                end
            end
            R_REQ: begin
                proto_err = lsu_ren;
                if (hs && !req_we_q) state_d = R_WAIT;
            end
            R_WAIT: begin
                proto_err = lsu_ren;
                if (mem_resp_valid) begin
                    resp_take = 1'b1;
                    state_d   = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // A write handshaking this cycle frees its entry, so the next candidate is one past the head.
    always_comb begin
        issue_rd      = free && (miss || ((state_q == R_REQ) && !rd_issued_q));
        rd_issue_addr = miss ? lsu_raddr : rd_addr_q;
        cand_idx      = head_q + PW'(deq);
        issue_wr      = free && !issue_rd && (state_q == R_IDLE) && !miss &&
                        (count_q > CW'(deq));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= R_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            wb_addr[tail_q] <= lsu_waddr;
            wb_data[tail_q] <= lsu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(WB_DEPTH));
            err_q   <= err_q | drop | proto_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_q   <= '0;
            rd_issued_q <= 1'b0;
        end else if (miss) begin
            rd_addr_q   <= lsu_raddr;
            rd_issued_q <= issue_rd;
        end else if (issue_rd) begin
            rd_issued_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (issue_rd) begin
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b0;
            req_addr_q  <= rd_issue_addr;
            req_wdata_q <= '0;
        end else if (issue_wr) begin
            req_valid_q <= 1'b1;
            req_we_q    <= 1'b1;
            req_addr_q  <= wb_addr[cand_idx];
            req_wdata_q <= wb_data[cand_idx];
        end else if (hs) begin
            req_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fwd_take || resp_take;
            if (fwd_take)       rdata_q <= fwd_data;
            else if (resp_take) rdata_q <= mem_resp_rdata;
        end
    end

    assign lsu_rvalid    = rvalid_q;
    assign lsu_rdata     = rdata_q;
    assign wb_full       = full_q;
    assign err_sticky    = err_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;

endmodule
